instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Downstream of the UART hex-nibble assembler: it accepts assembled 32-bit instruction words.
//  Words are written into a small on-chip instruction RAM at auto-incrementing addresses.
//  After the host signals end-of-load, it serves a 1-cycle-latency fetch port to the core.
//  It is the hand-off point between UART program download and execution.
// PARAMETERS
//  AW      4    address width; DEPTH = 2**AW words
//  XLEN    32   instruction word width
// PORTS
//  clk         in   1      single system clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  wr_data     in   XLEN   assembled instruction word
//  wr_valid    in   1      wr_data valid; word is accepted when wr_valid && wr_ready
//  wr_ready    out  1      loader can accept a word
//  load_done   in   1      1-cycle strobe: end of program download
//  reload      in   1      1-cycle strobe: discard program, return to LOAD
//  fetch_en    in   1      fetch request
//  fetch_addr  in   AW     fetch word address
//  fetch_data  out  XLEN   fetched word
//  fetch_valid out  1      fetch_data valid (one cycle after fetch_en)
//  loaded      out  1      1 in RUN state
//  word_count  out  AW+1   number of words stored (0..DEPTH)
//  overflow    out  1      sticky: wr_valid seen while full
// BEHAVIOUR
//  Reset values: state=LOAD, wr_ready=1, word_count=0, overflow=0, loaded=0,
//   fetch_valid=0, fetch_data=0. RAM contents are not reset.
//  FSM has 2 states.
//   LOAD: wr_ready = (word_count < DEPTH). Each accepted word writes RAM[word_count],
//    then word_count increments. load_done moves the FSM to RUN.
//   RUN: wr_ready=0 and loaded=1. reload moves the FSM to LOAD and clears word_count and overflow.
//  Fetch: honoured only in RUN.
//   fetch_en in cycle N gives fetch_valid=1 and fetch_data in cycle N+1.
//   fetch_data = RAM[fetch_addr] if fetch_addr < word_count, else NOP_WORD (32'h0000_0013).
//   fetch_en in LOAD gives fetch_valid=0 and fetch_data=0 in the next cycle.
//  Full: when word_count == DEPTH, wr_ready=0 and no write occurs.
//   A wr_valid asserted while full sets overflow (sticky until reload or rst).
//   word_count saturates at DEPTH and never wraps.
//  Simultaneous events:
//   wr_valid && wr_ready && load_done: the word is stored and counted, then the FSM enters RUN.
//   reload && fetch_en in RUN: the fetch is served from pre-reload contents and word_count,
//    then the FSM enters LOAD.
//   load_done in RUN, or reload in LOAD: ignored, except that reload in LOAD clears
//    word_count and overflow (restarts the download).
//  rst mid-download or mid-fetch: rst takes priority over all inputs.
//   All outputs return to reset values next cycle; the in-flight fetch is dropped.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   adds output checksum [XLEN-1:0], the XOR of all accepted words.
//   Cleared by rst/reload; updated in the same cycle as the write.
//   Lets the host verify the download over UART.
//  LOADER_CHECKSUM_EN undefined: no checksum port or logic. All other behaviour is identical.
// STRUCTURE
//  Shared package loader_pkg:
//   state enum {LOAD, RUN}
//   NOP_WORD = 32'h0000_0013
//  Sub-module instr_ram: single-port synchronous RAM, DEPTH x XLEN, registered read.
//   Writes occur in LOAD; reads occur in RUN, so one port suffices.
// TESTING
//  1 rst, write 3 words (11111111, 22222222, 33333333), load_done; then fetch addr 0,1,2,3
//   -> 11111111, 22222222, 33333333, 00000013, each 1 cycle after fetch_en; word_count=3, loaded=1.
//  2 write 16 words, then 17th with wr_valid held
//   -> wr_ready=0 after the 16th; overflow=1; word_count=16; RAM[0] unchanged.
//  3 last wr_valid in the same cycle as load_done
//   -> word stored, word_count increments, loaded=1 next cycle.
//  4 in RUN, reload together with fetch_en addr 1
//   -> fetch returns the old word; next cycle loaded=0, word_count=0, wr_ready=1.
//  5 rst asserted after 5 words
//   -> next cycle word_count=0, overflow=0, fetch_valid=0; a fetch issued in LOAD gives fetch_valid=0.
//  6 LOADER_CHECKSUM_EN: write A5A5A5A5 then 0F0F0F0F -> checksum = AAAAAAAA; after reload -> 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package loader_pkg;

    // Loader operating mode: accepting a download, or serving fetches.
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Source selected for fetch_data in the cycle after a fetch request.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_NOP  = 2'd2
    } fetch_src_t;

    // RISC-V "addi x0, x0, 0", returned for addresses beyond the loaded program.
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/instr_mem_loader_ram.sv
// Single-port synchronous instruction RAM, DEPTH x XLEN, registered read.
// Contents are not reset.
module instr_ram #(
    parameter int unsigned AW   = 4,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic            re_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [2**AW];
    logic [XLEN-1:0] rdata_q;

    // Write on we_i, registered read on re_i through the same address port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: stores downloaded words at auto-incrementing
// addresses, then serves a 1-cycle-latency fetch port once loading is done.
// Optional feature macro: LOADER_CHECKSUM_EN adds an XOR checksum output.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned AW   = 4,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic            load_done,
    input  logic            reload,
    input  logic            fetch_en,
    input  logic [AW-1:0]   fetch_addr,
    output logic [XLEN-1:0] fetch_data,
    output logic            fetch_valid,
    output logic            loaded,
    output logic [AW:0]     word_count,
    output logic            overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [XLEN-1:0] checksum
`endif
);

    localparam logic [AW:0] FULL = (AW+1)'(2**AW);

    state_t          state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            fv_q, fv_d;
    fetch_src_t      src_q, src_d;

    logic            ram_we, ram_re;
    logic [AW-1:0]   ram_addr;
    logic [XLEN-1:0] ram_rdata;

`ifdef LOADER_CHECKSUM_EN
    logic [XLEN-1:0] csum_q, csum_d;
`endif

    instr_ram #(
        .AW   (AW),
        .XLEN (XLEN)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (wr_data),
        .rdata_o (ram_rdata)
    );

    // State and status registers; rst overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            count_q <= '0;
            ovf_q   <= 1'b0;
            fv_q    <= 1'b0;
            src_q   <= SRC_ZERO;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            fv_q    <= fv_d;
            src_q   <= src_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state, RAM port steering and handshake outputs.
    // The single RAM port is addressed by word_count in LOAD and fetch_addr in RUN.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        fv_d     = 1'b0;
        src_d    = SRC_ZERO;
        wr_ready = 1'b0;
        loaded   = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = count_q[AW-1:0];
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            LOAD: begin
                wr_ready = (count_q < FULL);
                if (wr_valid && wr_ready) begin
                    ram_we  = 1'b1;
                    count_d = count_q + (AW+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ wr_data;
`endif
                end
                if (wr_valid && !wr_ready) begin
                    ovf_d = 1'b1;
                end
                if (load_done) begin
                    state_d = RUN;
                end
                if (reload) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            RUN: begin
                loaded   = 1'b1;
                ram_addr = fetch_addr;
                if (fetch_en) begin
                    ram_re = 1'b1;
                    fv_d   = 1'b1;
                    src_d  = ({1'b0, fetch_addr} < count_q) ? SRC_RAM : SRC_NOP;
                end
                if (reload) begin
                    state_d = LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Fetch data mux: RAM word, NOP past the program end, zero otherwise.
    always_comb begin
        case (src_q)
            SRC_RAM: fetch_data = ram_rdata;
            SRC_NOP: fetch_data = XLEN'(NOP_WORD);
            default: fetch_data = '0;
        endcase
    end

    assign fetch_valid = fv_q;
    assign word_count  = count_q;
    assign overflow    = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum    = csum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: fetch responses go through a
// scoreboard queue, status outputs are compared against a behavioural model.
// Honours LOADER_CHECKSUM_EN when defined.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        load_done = 1'b0;
    logic        reload = 1'b0;
    logic        fetch_en = 1'b0;
    logic [3:0]  fetch_addr = '0;
    logic [31:0] fetch_data;
    logic        fetch_valid;
    logic        loaded;
    logic [4:0]  word_count;
    logic        overflow;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    instr_mem_loader #(.AW(4), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .load_done   (load_done),
        .reload      (reload),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .loaded      (loaded),
        .word_count  (word_count),
        .overflow    (overflow)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          at;
        bit          vld;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    // Behavioural model of the loader as seen from outside.
    logic [31:0] mmem [16];
    int          mcount = 0;
    bit          movf = 0;
    bit          mloaded = 0;
    logic [31:0] mcsum = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares fetch output against the scoreboard in the cycle it is due.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].at == cyc) begin
            chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, sbq[0].vld});
            chk("fetch_data", fetch_data, sbq[0].data);
            void'(sbq.pop_front());
        end else if (sbq.size() > 0 && sbq[0].at < cyc) begin
            chk("fetch_missed", 32'(sbq[0].at), 32'(cyc));
            void'(sbq.pop_front());
        end else if (fetch_valid === 1'b1) begin
            chk("fetch_unexpected", {31'b0, fetch_valid}, 32'd0);
        end
    end

    // Apply the spec rules for the inputs about to be captured at the next edge.
    task automatic model_edge();
        exp_t e;
        e.at = cyc + 1;
        if (rst) begin
            if (fetch_en) begin e.vld = 0; e.data = '0; sbq.push_back(e); end
            mcount = 0; movf = 0; mloaded = 0; mcsum = '0;
        end else if (!mloaded) begin
            if (fetch_en) begin e.vld = 0; e.data = '0; sbq.push_back(e); end
            if (reload) begin
                mcount = 0; movf = 0; mcsum = '0;
            end else begin
                if (wr_valid) begin
                    if (mcount < 16) begin
                        mmem[mcount] = wr_data;
                        mcount++;
                        mcsum ^= wr_data;
                    end else begin
                        movf = 1;
                    end
                end
                if (load_done) mloaded = 1;
            end
        end else begin
            if (fetch_en) begin
                e.vld  = 1;
                e.data = (int'(fetch_addr) < mcount) ? mmem[fetch_addr] : 32'h0000_0013;
                sbq.push_back(e);
            end
            if (reload) begin
                mloaded = 0; mcount = 0; movf = 0; mcsum = '0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        rst = 0; wr_valid = 0; load_done = 0; reload = 0; fetch_en = 0;
    endtask

    task automatic check_status();
        chk("word_count", 32'(word_count), 32'(mcount));
        chk("overflow", {31'b0, overflow}, {31'b0, movf});
        chk("loaded", {31'b0, loaded}, {31'b0, mloaded});
        chk("wr_ready", {31'b0, wr_ready}, {31'b0, (!mloaded && mcount < 16)});
`ifdef LOADER_CHECKSUM_EN
        chk("checksum", checksum, mcsum);
`endif
    endtask

    task automatic wr(input logic [31:0] d);
        wr_valid = 1; wr_data = d;
        tick();
        check_status();
    endtask

    task automatic fetch(input int a);
        fetch_en = 1; fetch_addr = 4'(a);
        tick();
        check_status();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        rst = 1; tick();
        rst = 1; tick();
        check_status();
        chk("reset_fetch_data", fetch_data, 32'd0);

        // Three words, load_done, fetch 0..3
        wr(32'h11111111); wr(32'h22222222); wr(32'h33333333);
        load_done = 1; tick(); check_status();
        for (int a = 0; a < 4; a++) fetch(a);
        chk("t1_word_count", 32'(word_count), 32'd3);

        // reload together with fetch in RUN
        reload = 1; fetch_en = 1; fetch_addr = 4'd1; tick(); check_status();
        tick();

        // Fill to 16, then hold wr_valid while full
        for (int i = 0; i < 16; i++) wr(32'hA000_0000 + 32'(i));
        for (int i = 0; i < 3; i++) wr(32'hDEADBEEF);
        chk("t2_word_count", 32'(word_count), 32'd16);
        chk("t2_overflow", {31'b0, overflow}, 32'd1);
        load_done = 1; tick(); check_status();
        fetch(0); fetch(15);
        reload = 1; tick(); check_status();

        // Last word together with load_done
        wr(32'h0000_00AA);
        wr_valid = 1; wr_data = 32'h0000_00BB; load_done = 1; tick(); check_status();
        chk("t3_loaded", {31'b0, loaded}, 32'd1);
        fetch(1); fetch(2);
        load_done = 1; tick(); check_status();      // ignored in RUN
        reload = 1; tick(); check_status();

        // rst after five words, then fetch in LOAD
        for (int i = 0; i < 5; i++) wr(32'h5000_0000 + 32'(i));
        rst = 1; tick(); check_status();
        fetch(0);
        // rst alongside a fetch in RUN drops it
        wr(32'h7777_7777); load_done = 1; tick();
        rst = 1; fetch_en = 1; fetch_addr = 4'd0; tick(); check_status();

`ifdef LOADER_CHECKSUM_EN
        wr(32'hA5A5A5A5); wr(32'h0F0F0F0F);
        chk("t6_checksum", checksum, 32'hAAAAAAAA);
        reload = 1; tick(); check_status();
        chk("t6_checksum_clr", checksum, 32'd0);
`endif

        // Randomized episodes
        for (int ep = 0; ep < 10; ep++) begin
            if (ep % 3 == 0) rst = 1; else reload = 1;
            tick(); check_status();
            begin
                int n;
                n = $urandom_range(0, 19);
                for (int i = 0; i < n; i++) begin
                    wr_valid = ($urandom_range(0, 3) != 0);
                    wr_data = $urandom;
                    fetch_en = ($urandom_range(0, 4) == 0);
                    fetch_addr = 4'($urandom);
                    if (i == n - 1 && $urandom_range(0, 1) == 1) load_done = 1;
                    tick(); check_status();
                end
            end
            if (!mloaded) begin load_done = 1; tick(); check_status(); end
            for (int i = 0; i < 20; i++) begin
                fetch_en = ($urandom_range(0, 3) != 0);
                fetch_addr = 4'($urandom);
                load_done = ($urandom_range(0, 7) == 0);
                if (i == 19) reload = $urandom_range(0, 1) == 1;
                tick(); check_status();
            end
        end

        tick(); tick();
        chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
